// File: rtl/btn_sw_debounce_if.sv
// Pin-side bundle of the button/switch conditioner: raw pins in, clean levels and edge pulses out.
// No handshake: raw pins are free-running levels; every output is a register updated once per clock.
interface btn_sw_debounce_if #(
  parameter int N_BTN = 4,
  parameter int N_SW  = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_db;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_SW-1:0]  sw_raw;
  logic [N_SW-1:0]  sw_db;
  logic [N_SW-1:0]  sw_change;

  modport master (
    output btn_raw, sw_raw,
    input  btn_db, btn_press, btn_release, sw_db, sw_change
  );

  modport slave (
    input  btn_raw, sw_raw,
    output btn_db, btn_press, btn_release, sw_db, sw_change
  );
endinterface

// File: rtl/btn_sw_debounce.sv
// Button/switch input conditioner: 2-flop synchroniser plus stable-count debounce per pin,
// with registered clean levels and one-cycle edge pulses.
module btn_sw_debounce #(
  parameter int N_BTN           = 4,
  parameter int N_SW            = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic CLK100MHZ,
  input logic ck_rst,
  btn_sw_debounce_if.slave io
);
  localparam int N_CH = N_BTN + N_SW;
  localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Buttons occupy the low channel indices, switches the high ones.
  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] db_all;
  logic [N_CH-1:0] rise_all;
  logic [N_CH-1:0] fall_all;

  assign raw = {io.sw_raw, io.btn_raw};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          db;
    logic          rise;
    logic          fall;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
      if (!ck_rst) begin
        s1   <= 1'b0;
        s2   <= 1'b0;
        db   <= 1'b0;
        rise <= 1'b0;
        fall <= 1'b0;
        cnt  <= '0;
      end else begin
        s1   <= raw[i];
        s2   <= s1;
        rise <= 1'b0;
        fall <= 1'b0;
        if (s2 == db) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          // Pulses land in the same cycle the new level appears on db.
          db   <= s2;
          cnt  <= '0;
          rise <= s2;
          fall <= ~s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign db_all[i]   = db;
    assign rise_all[i] = rise;
    assign fall_all[i] = fall;
  end

  assign io.btn_db      = db_all[N_BTN-1:0];
  assign io.btn_press   = rise_all[N_BTN-1:0];
  assign io.btn_release = fall_all[N_BTN-1:0];
  assign io.sw_db       = db_all[N_CH-1:N_BTN];
  assign io.sw_change   = rise_all[N_CH-1:N_BTN] | fall_all[N_CH-1:N_BTN];
endmodule

// File: doc/btn_sw_debounce.md
Name: btn_sw_debounce

Overview:
- Input conditioner for the board's mechanical push-buttons and slide switches; the input end of the switch/button-to-LED path.
- Synchronises each raw pin into the clock domain, rejects contact bounce, and presents clean levels plus one-cycle edge pulses to downstream logic such as LED drivers and control FSMs.
- All bits are independent, identical per-bit channels.

Parameters:
- N_BTN, 4, number of push-button channels.
- N_SW, 4, number of slide-switch channels.
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable clock cycles needed to accept a new level (10 ms at 100 MHz); legal range >= 1.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz board oscillator.
- ck_rst  input  1  reset, asynchronous assert, active-low.
- btn_raw  input  N_BTN  raw push-button pins; asynchronous, bouncing, 1 = pressed.
- sw_raw  input  N_SW  raw slide-switch pins; asynchronous, bouncing, 1 = up.
- btn_db  output  N_BTN  debounced button levels.
- btn_press  output  N_BTN  one-cycle pulse when btn_db rises.
- btn_release  output  N_BTN  one-cycle pulse when btn_db falls.
- sw_db  output  N_SW  debounced switch levels.
- sw_change  output  N_SW  one-cycle pulse on any change of sw_db.

Behaviour:
- Clock and reset (already decided): one clock, CLK100MHZ. Reset ck_rst is asynchronous and active-low.
- While ck_rst = 0, all state clears immediately: sync flops, counters, all *_db outputs and all pulse outputs are 0.
- Synchroniser: each raw bit passes through a 2-flop synchroniser (s1, s2), reset to 0. No other logic reads the raw pins.
- Counter: each channel has a counter of width max(1, clog2(DEBOUNCE_CYCLES)), reset to 0.
- Per-channel rule, evaluated every clock edge:
  - s2 == db: cnt <= 0; db holds; pulse <= 0.
  - s2 != db and cnt == DEBOUNCE_CYCLES-1: db <= s2; cnt <= 0; pulse <= 1 for exactly one cycle.
  - s2 != db otherwise: cnt <= cnt + 1; pulse <= 0.
- Pulse timing: all pulses are registered and assert in the same cycle db takes its new value.
  - btn_press = rising edge of db; btn_release = falling edge of db; sw_change = either edge.
- Latency: raw change first sampled at edge k, then held steady. db updates at edge k+1+DEBOUNCE_CYCLES. With DEBOUNCE_CYCLES = 1, that is edge k+2.
- Bounce rejection:
  - Any return of s2 to db before the count completes resets cnt to 0; no output change.
  - A pulse lasting DEBOUNCE_CYCLES-1 cycles at s2 is always rejected.
- Channel independence: channels never interact. Simultaneous changes on several bits update on the same edge, each with its own pulse.
- Counter range: cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- After reset release:
  - Inputs already at 1 are treated as a change from 0.
  - A switch that is up during reset produces sw_db = 1 plus one sw_change pulse after the normal latency.
  - A button held through reset produces one btn_press pulse after the normal latency.
- Reset mid-count: counting is abandoned. After release, counting restarts from 0 against db = 0.
- Outputs are pure registers; no combinational path from inputs to outputs.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 8.
- Reset with sw_raw = 4'hF, btn_raw = 0:
  - Required: all outputs 0 while ck_rst = 0.
  - After release, first sampling edge k: sw_db = 4'hF at edge k+9.
  - sw_change = 4'hF for exactly one cycle at edge k+9; btn outputs stay 0.
- Clean press/release: btn_raw[0] 0->1 sampled at edge k, held 30 cycles, then 1->0.
  - Required: btn_db[0] = 1 at edge k+9; btn_press = 4'b0001 for one cycle.
  - Required: btn_db[0] = 0 nine cycles after the release is sampled; btn_release = 4'b0001 for one cycle.
- Bounce: btn_raw[1] toggles high 5 cycles / low 3 cycles, four times, then stays high from edge m.
  - Required: no output activity during the bounce.
  - Required: btn_db[1] rises at edge m+9 with exactly one btn_press[1] pulse.
- Glitch: sw_raw[2] high for 7 cycles, then low.
  - Required: sw_db and sw_change unchanged; internal cnt returns to 0.
- Simultaneous: btn_raw[2] and sw_raw[3] rise on the same cycle.
  - Required: btn_db[2] and sw_db[3] update on the same edge.
  - Required: btn_press = 4'b0100 and sw_change = 4'b1000 in that cycle; other bits unaffected.
- Reset mid-count: btn_raw[3] held high; ck_rst asserted once cnt = 5.
  - Required: immediate clear, asynchronous, no clock edge needed.
  - Required: after release, btn_db[3] rises a full 9 cycles after re-sampling, with one pulse.
